// File: rtl/interp_pkg.sv
// rtl/interp_pkg.sv - shared DAC constants, feeder FSM encoding and round/saturate helper
package interp_pkg;

  localparam int DAC_W   = 18;
  localparam int DAC_MAX = 131071;
  localparam int DAC_MIN = -131072;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } feeder_state_e;

  // acc arrives sign-extended to 64 bits, so the half-LSB add cannot overflow for any ACC_W <= 63
  function automatic logic signed [DAC_W-1:0] round_sat(input logic signed [63:0] acc,
                                                        input int frac_shift);
    logic signed [63:0] r;
    logic signed [63:0] q;
    logic signed [DAC_W-1:0] res;
    r = acc + (64'sd1 <<< (frac_shift - 1));
    q = r >>> frac_shift;
    if (q > 64'(DAC_MAX)) res = DAC_W'(DAC_MAX);
    else if (q < 64'(DAC_MIN)) res = DAC_W'(DAC_MIN);
    else res = q[DAC_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous circular FIFO with occupancy output
module sample_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   fill
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          push_ok, pop_ok;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rd_q];
  assign fill    = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_ok) rd_q <= rd_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/dac_sample_feeder.sv
// rtl/dac_sample_feeder.sv - FIR-to-PCM1702 sample pacer; FEEDER_UNDERRUN_HOLD_EN re-issues last sample on underrun
module dac_sample_feeder
  import interp_pkg::*;
#(
  parameter int ACC_W      = 36,
  parameter int FRAC_SHIFT = 17,
  parameter int DEPTH      = 8,
  parameter int TICK_DIV   = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fir_valid,
  input  logic signed [ACC_W-1:0]   fir_data,
  output logic                      fir_ready,
  output logic                      sample_rdy,
  output logic signed [DAC_W-1:0]   data,
  input  logic                      shift_done,
  output logic                      underrun,
  output logic                      late,
  output logic [$clog2(DEPTH):0]    fill
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0]    tick_cnt_q, tick_cnt_d;
  logic             tick;
  logic [DAC_W-1:0] conv, head;
  logic             push, pop, full, empty;
  feeder_state_e    state_q;
  logic             pending_q, sample_rdy_q, underrun_q, late_q;
  logic [DAC_W-1:0] data_q;

  assign conv       = round_sat(64'(fir_data), FRAC_SHIFT);
  assign tick       = (tick_cnt_q == CW'(TICK_DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  assign push       = fir_valid && !full;
  assign pop        = (state_q == ST_IDLE) && pending_q && !empty;

  sample_fifo #(.W(DAC_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (conv),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .fill      (fill)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q   <= '0;
      pending_q    <= 1'b0;
      state_q      <= ST_IDLE;
      sample_rdy_q <= 1'b0;
      data_q       <= '0;
      underrun_q   <= 1'b0;
      late_q       <= 1'b0;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      sample_rdy_q <= 1'b0;
      // a tick only sets pending when clear; IDLE only clears it when set, so the two never collide
      if (tick && pending_q)  late_q    <= 1'b1;
      if (tick && !pending_q) pending_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (pending_q) begin
            pending_q <= 1'b0;
            if (!empty) begin
              data_q       <= head;
              state_q      <= ST_ISSUE;
              sample_rdy_q <= 1'b1;
            end else begin
              underrun_q <= 1'b1;
`ifdef FEEDER_UNDERRUN_HOLD_EN
              state_q      <= ST_ISSUE;
              sample_rdy_q <= 1'b1;
`endif
            end
          end
        end
        ST_ISSUE: state_q <= ST_BUSY;
        ST_BUSY:  if (shift_done) state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign fir_ready  = !full;
  assign sample_rdy = sample_rdy_q;
  assign data       = data_q;
  assign underrun   = underrun_q;
  assign late       = late_q;

endmodule

// File: tb/tb_dac_sample_feeder.sv
// tb/tb_dac_sample_feeder.sv - randomized self-checking bench for dac_sample_feeder
module tb_dac_sample_feeder;

  localparam int ACC_W    = 36;
  localparam int FS       = 17;
  localparam int DEPTH    = 8;
  localparam int TICK_DIV = 256;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    fir_valid;
  logic signed [ACC_W-1:0] fir_data;
  logic                    fir_ready;
  logic                    sample_rdy;
  logic signed [17:0]      data;
  logic                    shift_done;
  logic                    underrun;
  logic                    late;
  logic [3:0]              fill;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [17:0] pulse_data[$];
  int          pulse_cyc[$];
  bit          sd_auto = 1'b0;
  int          sd_delay = 10;
  int          stable_err = 0;

  dac_sample_feeder #(.ACC_W(ACC_W), .FRAC_SHIFT(FS), .DEPTH(DEPTH), .TICK_DIV(TICK_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .fir_valid  (fir_valid),
    .fir_data   (fir_data),
    .fir_ready  (fir_ready),
    .sample_rdy (sample_rdy),
    .data       (data),
    .shift_done (shift_done),
    .underrun   (underrun),
    .late       (late),
    .fill       (fill)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference conversion: round half up by floor division, then clamp to the 18-bit range
  function automatic logic [17:0] model(input longint x);
    longint r, q;
    r = x + (longint'(1) << (FS - 1));
    if (r >= 0) q = r / (longint'(1) << FS);
    else q = -((-r + (longint'(1) << FS) - 1) / (longint'(1) << FS));
    if (q > 131071) q = 131071;
    if (q < -131072) q = -131072;
    return 18'(q);
  endfunction

  function automatic longint rand_acc();
    logic [35:0] raw;
    longint v;
    raw = 36'({$urandom(), $urandom()});
    v = longint'($signed(raw));
    v = v >>> $urandom_range(0, 18);
    return v;
  endfunction

  // DAC interface model: logs every pulse, optionally answers with shift_done and watches data
  initial begin
    logic [17:0] held;
    shift_done = 1'b0;
    forever begin
      @(negedge clk);
      if (sample_rdy === 1'b1) begin
        pulse_data.push_back(data);
        pulse_cyc.push_back(cyc);
        if (sd_auto) begin
          held = data;
          for (int i = 0; i < sd_delay; i++) begin
            @(negedge clk);
            if (rst) break;
            if (data !== held) stable_err++;
          end
          if (!rst) begin
            shift_done = 1'b1;
            @(negedge clk);
            shift_done = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    fir_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    pulse_data.delete();
    pulse_cyc.delete();
    stable_err = 0;
  endtask

  task automatic push_word(input longint v, input int max_wait, output bit ok);
    ok = 1'b0;
    fir_data = 36'(v);
    fir_valid = 1'b1;
    for (int i = 0; i < max_wait && !ok; i++) begin
      if (fir_ready) ok = 1'b1;
      @(negedge clk);
    end
    fir_valid = 1'b0;
  endtask

  task automatic wait_pulses(input int n, input int budget);
    for (int i = 0; i < budget && pulse_data.size() < n; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_stream(input string name, input longint vals[$]);
    checks++;
    if (pulse_data.size() < vals.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d pulses expected %0d", name, pulse_data.size(), vals.size());
    end
    for (int i = 0; i < vals.size() && i < pulse_data.size(); i++) begin
      checks++;
      if (pulse_data[i] !== model(vals[i])) begin
        errors++;
        $display("FAIL %s[%0d]: got %0d expected %0d", name, i,
                 $signed(pulse_data[i]), $signed(model(vals[i])));
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (fir_ready !== 1'b1) begin errors++; $display("FAIL rst_fir_ready: got %b expected 1", fir_ready); end
    checks++; if (fill !== 4'd0) begin errors++; $display("FAIL rst_fill: got %0d expected 0", fill); end
    checks++; if (sample_rdy !== 1'b0) begin errors++; $display("FAIL rst_sample_rdy: got %b expected 0", sample_rdy); end
    checks++; if (data !== 18'd0) begin errors++; $display("FAIL rst_data: got %0d expected 0", data); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun: got %b expected 0", underrun); end
    checks++; if (late !== 1'b0) begin errors++; $display("FAIL rst_late: got %b expected 0", late); end
  endtask

  task automatic test_rounding();
    longint vals[$];
    bit ok;
    do_reset();
    sd_auto = 1'b1;
    sd_delay = 10;
    vals = '{(longint'(5) << 17) + 65536, (longint'(5) << 17) + 65535, -((longint'(5) << 17) + 65536)};
    for (int i = 0; i < 5; i++) vals.push_back(rand_acc());
    foreach (vals[i]) begin
      push_word(vals[i], 4, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL round_push[%0d]: got not-accepted expected accepted", i); end
    end
    checks++;
    if (fill !== 4'(vals.size())) begin errors++; $display("FAIL round_fill: got %0d expected %0d", fill, vals.size()); end
    wait_pulses(vals.size(), (vals.size() + 2) * TICK_DIV);
    check_stream("round", vals);
  endtask

  task automatic test_saturation();
    longint vals[$];
    bit ok;
    do_reset();
    sd_auto = 1'b1;
    sd_delay = 10;
    vals = '{longint'(1) << 34, -(longint'(1) << 34), (longint'(1) << 35) - 1, -(longint'(1) << 35),
             (longint'(131071) << 17) + 65535, -(longint'(131072) << 17)};
    foreach (vals[i]) push_word(vals[i], 4, ok);
    wait_pulses(vals.size(), (vals.size() + 2) * TICK_DIV);
    check_stream("sat", vals);
  endtask

  task automatic test_pacing();
    longint vals[$];
    bit ok;
    do_reset();
    sd_auto = 1'b1;
    sd_delay = 100;
    for (int i = 0; i < 3; i++) vals.push_back(rand_acc());
    foreach (vals[i]) push_word(vals[i], 4, ok);
    wait_pulses(3, 5 * TICK_DIV);
    repeat (110) @(negedge clk);
    check_stream("pace", vals);
    for (int i = 1; i < 3 && i < pulse_cyc.size(); i++) begin
      checks++;
      if (pulse_cyc[i] - pulse_cyc[i-1] !== TICK_DIV) begin
        errors++;
        $display("FAIL pace_spacing[%0d]: got %0d cycles expected %0d", i, pulse_cyc[i] - pulse_cyc[i-1], TICK_DIV);
      end
    end
    checks++;
    if (stable_err !== 0) begin errors++; $display("FAIL pace_data_stable: got %0d changes expected 0", stable_err); end
  endtask

  task automatic test_back_to_back();
    longint vals[$];
    bit ok;
    do_reset();
    sd_auto = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) vals.push_back(rand_acc());
    for (int i = 0; i < DEPTH; i++) push_word(vals[i], 4, ok);
    checks++;
    if (fill !== 4'(DEPTH)) begin errors++; $display("FAIL bp_fill_full: got %0d expected %0d", fill, DEPTH); end
    checks++;
    if (fir_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b expected 0", fir_ready); end
    push_word(vals[DEPTH], 2 * TICK_DIV, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_push9: got not-accepted expected accepted"); end
    checks++;
    if (fill !== 4'(DEPTH)) begin errors++; $display("FAIL bp_fill_refill: got %0d expected %0d", fill, DEPTH); end
    repeat (5) @(negedge clk);
    sd_auto = 1'b1;
    sd_delay = 10;
    shift_done = 1'b1;
    @(negedge clk);
    shift_done = 1'b0;
    push_word(vals[DEPTH+1], 2 * TICK_DIV, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_push10: got not-accepted expected accepted"); end
    wait_pulses(DEPTH + 2, (DEPTH + 4) * TICK_DIV);
    check_stream("bp", vals);
  endtask

  task automatic test_underrun();
    longint vals[$];
    bit ok;
    int expect_n;
    do_reset();
    sd_auto = 1'b1;
    sd_delay = 10;
    vals.push_back((longint'(1234) << 17) + 3);
    push_word(vals[0], 4, ok);
    wait_pulses(1, 3 * TICK_DIV);
    for (int i = 0; i < 2 * TICK_DIV && underrun !== 1'b1; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    checks++;
    if (underrun !== 1'b1) begin errors++; $display("FAIL ur_flag: got %b expected 1", underrun); end
`ifdef FEEDER_UNDERRUN_HOLD_EN
    expect_n = 2;
    vals.push_back(vals[0]);
`else
    expect_n = 1;
`endif
    checks++;
    if (pulse_data.size() !== expect_n) begin
      errors++;
      $display("FAIL ur_pulses: got %0d expected %0d", pulse_data.size(), expect_n);
    end
    check_stream("ur", vals);
    checks++;
    if (data !== model(vals[0])) begin errors++; $display("FAIL ur_data_hold: got %0d expected %0d", data, $signed(model(vals[0]))); end
    checks++;
    if (late !== 1'b0) begin errors++; $display("FAIL ur_late: got %b expected 0", late); end
  endtask

  task automatic test_late_reset();
    bit ok;
    do_reset();
    sd_auto = 1'b0;
    push_word((longint'(777) << 17), 4, ok);
    wait_pulses(1, 3 * TICK_DIV);
    repeat (TICK_DIV * 5 / 2) @(negedge clk);
    checks++;
    if (late !== 1'b1) begin errors++; $display("FAIL late_flag: got %b expected 1", late); end
    checks++;
    if (data !== 18'sd777) begin errors++; $display("FAIL late_data: got %0d expected 777", data); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (late !== 1'b0) begin errors++; $display("FAIL mid_rst_late: got %b expected 0", late); end
    checks++; if (data !== 18'd0) begin errors++; $display("FAIL mid_rst_data: got %0d expected 0", data); end
    checks++; if (sample_rdy !== 1'b0) begin errors++; $display("FAIL mid_rst_sample_rdy: got %b expected 0", sample_rdy); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL mid_rst_underrun: got %b expected 0", underrun); end
    checks++; if (fill !== 4'd0) begin errors++; $display("FAIL mid_rst_fill: got %0d expected 0", fill); end
    checks++; if (fir_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_fir_ready: got %b expected 1", fir_ready); end
  endtask

  initial begin
    rst = 1'b1;
    fir_valid = 1'b0;
    fir_data = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_rounding();
    test_saturation();
    test_pacing();
    test_back_to_back();
    test_underrun();
    test_late_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
